pattern_recorder: RTL and testbench
===================================

PATTERN_RECORDER -- requirements
Module: pattern_recorder

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entry count (power of two, 4..64).
REQ-002 SHALL have port clock  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port counter10h  input  10  current game timestamp from game_clock.
REQ-005 SHALL have port user_input  input  8  raw key state, one bit per lane.
REQ-006 SHALL have port record_en  input  1  capture enable.
REQ-007 SHALL have port clear  input  1  synchronous flush of FIFO and flags.
REQ-008 SHALL have port rd_req  input  1  pop request from the downstream reader.
REQ-009 SHALL have port pattern_with_timestamp  output  18  popped record: [17:8] timestamp, [7:0] pattern.
REQ-010 SHALL have port rd_valid  output  1  pattern_with_timestamp valid this cycle.
REQ-011 SHALL have port count  output  clog2(DEPTH)+1  stored entries.
REQ-012 SHALL have port empty / full / overflow  output  1 each  FIFO status; overflow sticky.

Function
REQ-013 SHALL keep last_pattern register holding the most recently accepted key state.
REQ-014 SHALL detect a change when the accepted key state differs from last_pattern; on every change, SHALL update last_pattern regardless of record_en.
REQ-015 SHALL, on a change at edge k with record_en=1, write {counter10h sampled at edge k, new key state} into the FIFO at edge k; count reflects it after edge k.
REQ-016 SHALL NOT write entries while record_en=0 or when user_input equals last_pattern.
REQ-017 SHALL store timestamps verbatim; counter10h wrap 1023->0 needs no special handling.
REQ-018 SHALL, at an edge with rd_req=1 and empty=0, drive the head entry on pattern_with_timestamp and assert rd_valid for exactly one cycle.
REQ-019 SHALL, on rd_req=1 while empty, leave pattern_with_timestamp unchanged and keep rd_valid=0.
REQ-020 SHALL hold pattern_with_timestamp at its last popped value between pops.
REQ-021 SHALL, on a write while full without a simultaneous pop, drop the entry and set overflow.
REQ-022 SHALL, on simultaneous write and pop while full, perform both; count stays DEPTH; overflow unchanged.
REQ-023 SHALL, on simultaneous write and pop while empty, pop nothing (rd_valid=0) and store the write; count becomes 1.
REQ-024 SHALL give clear priority over write and pop: count=0, overflow=0, rd_valid=0, last_pattern still updated.
REQ-025 SHALL derive empty=(count==0) and full=(count==DEPTH) combinationally from count.
REQ-026 SHALL use wrap-around read/write pointers of clog2(DEPTH) bits.

Reset
REQ-027 SHALL, while reset_n=0, asynchronously force count=0, pointers=0, last_pattern=8'h00, pattern_with_timestamp=18'h0, rd_valid=0, overflow=0, debounce state cleared.
REQ-028 SHALL discard all stored entries on reset mid-operation; FIFO memory contents need not be cleared.
REQ-029 SHALL resume recording at the first rising edge after reset_n deasserts.

Configuration
REQ-030 SHALL, with macro PATTERN_RECORDER_DEBOUNCE_EN defined, accept a new key state only after user_input holds the same value differing from last_pattern for 4 consecutive rising edges; the timestamp is counter10h at the 4th edge; any change restarts the count.
REQ-031 SHALL, without PATTERN_RECORDER_DEBOUNCE_EN, accept user_input directly each edge (REQ-015 timing) and contain no debounce logic.

Verification
REQ-032 Reset, record_en=1, counter10h=10'd5, user_input 8'h00->8'h01 -> after one edge count=1; rd_req pulse -> rd_valid=1, pattern_with_timestamp=18'h00501.
REQ-033 user_input held 8'h01 for 20 cycles, then record_en=0 with change to 8'h03 -> count stays 1; re-enable with no change -> no new entry.
REQ-034 DEPTH=16, 17 alternating changes with no reads -> full=1, count=16, overflow=1; 17th entry absent on readback; entries read in write order.
REQ-035 Full FIFO, change and rd_req on same edge -> rd_valid=1 with oldest entry, count=16, overflow=0; clear asserted with rd_req -> count=0, rd_valid=0.
REQ-036 counter10h 10'd1023 then 10'd0 with changes 8'h80, 8'h40 -> records 18'h3FF80 then 18'h00040 in order.
REQ-037 PATTERN_RECORDER_DEBOUNCE_EN defined: 3-cycle glitch to 8'h02 -> no entry; 4-cycle hold of 8'h02 starting at counter10h=10'd100 -> entry 18'h06702 (timestamp 103).

Source files
------------

// File: rtl/pattern_recorder.sv
// ============================================================================
// pattern_recorder : records key-state changes with game timestamps in a FIFO
// Optional debounce: define PATTERN_RECORDER_DEBOUNCE_EN     Revision: 1.0
// ============================================================================
`default_nettype none

module pattern_recorder #(
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [9:0]               counter10h,
    input  logic [7:0]               user_input,
    input  logic                     record_en,
    input  logic                     clear,
    input  logic                     rd_req,
    output logic [17:0]              pattern_with_timestamp,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [17:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    last_pattern_q, last_pattern_d;
    logic [17:0]   dout_q, dout_d;
    logic          rd_valid_q, rd_valid_d;
    logic          overflow_q, overflow_d;

    logic          accept;
    logic [7:0]    new_pattern;
    logic          wr_en, rd_en, do_write;

`ifdef PATTERN_RECORDER_DEBOUNCE_EN
    logic [7:0] cand_q, cand_d;
    logic [1:0] stable_q, stable_d;

    // stable_q counts earlier consecutive edges that saw cand_q; the 4th edge accepts
    always_comb begin
        cand_d      = cand_q;
        stable_d    = stable_q;
        accept      = 1'b0;
        new_pattern = user_input;
        if (user_input == last_pattern_q) begin
            stable_d = 2'd0;
        end else if (stable_q != 2'd0 && user_input == cand_q) begin
            if (stable_q == 2'd3) begin
                accept   = 1'b1;
                stable_d = 2'd0;
            end else begin
                stable_d = stable_q + 2'd1;
            end
        end else begin
            cand_d   = user_input;
            stable_d = 2'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cand_q   <= 8'h00;
            stable_q <= 2'd0;
        end else begin
            cand_q   <= cand_d;
            stable_q <= stable_d;
        end
    end
`else
    assign accept      = (user_input != last_pattern_q);
    assign new_pattern = user_input;
`endif

    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign wr_en    = accept && record_en;
    assign rd_en    = rd_req && !empty;
    // A write into a full FIFO only fits when a pop frees the head slot this edge
    assign do_write = wr_en && (!full || rd_en) && !clear;

    always_comb begin
        last_pattern_d = accept ? new_pattern : last_pattern_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
        dout_d         = dout_q;
        rd_valid_d     = 1'b0;
        overflow_d     = overflow_q;
        if (clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (rd_en) begin
                dout_d     = mem[rd_ptr_q];
                rd_ptr_d   = rd_ptr_q + 1'b1;
                rd_valid_d = 1'b1;
            end
            if (do_write) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (wr_en && full && !rd_en) begin
                overflow_d = 1'b1;
            end
            count_d = count_q + CW'(do_write) - CW'(rd_en);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            last_pattern_q <= 8'h00;
            dout_q         <= 18'h0;
            rd_valid_q     <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            last_pattern_q <= last_pattern_d;
            dout_q         <= dout_d;
            rd_valid_q     <= rd_valid_d;
            overflow_q     <= overflow_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_write) begin
            mem[wr_ptr_q] <= {counter10h, new_pattern};
        end
    end

    assign pattern_with_timestamp = dout_q;
    assign rd_valid               = rd_valid_q;
    assign count                  = count_q;
    assign overflow               = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_pattern_recorder.sv
// ============================================================================
// tb_pattern_recorder : directed + random checks against a queue-based model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pattern_recorder;

    localparam int DEPTH = 16;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [9:0]  counter10h;
    logic [7:0]  user_input;
    logic        record_en, clear, rd_req;
    logic [17:0] pattern_with_timestamp;
    logic        rd_valid;
    logic [4:0]  count;
    logic        empty, full, overflow;

    pattern_recorder #(.DEPTH(DEPTH)) dut (
        .clock                  (clock),
        .reset_n                (reset_n),
        .counter10h             (counter10h),
        .user_input             (user_input),
        .record_en              (record_en),
        .clear                  (clear),
        .rd_req                 (rd_req),
        .pattern_with_timestamp (pattern_with_timestamp),
        .rd_valid               (rd_valid),
        .count                  (count),
        .empty                  (empty),
        .full                   (full),
        .overflow               (overflow)
    );

    always #5 clock = ~clock;

    // Reference model state
    logic [17:0] m_q [$];
    logic [7:0]  m_hist [$];
    logic [7:0]  m_last;
    logic [17:0] m_out;
    logic        m_rv, m_ovf;

    int n_pass   = 0;
    int n_fail   = 0;
    int n_checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_hist.delete();
        m_last = 8'h00;
        m_out  = 18'h0;
        m_rv   = 1'b0;
        m_ovf  = 1'b0;
    endtask

    task automatic model_edge();
        logic acc;
        logic popped;
`ifdef PATTERN_RECORDER_DEBOUNCE_EN
        m_hist.push_back(user_input);
        if (m_hist.size() > 4) void'(m_hist.pop_front());
        acc = (m_hist.size() == 4) && (m_hist[0] == m_hist[1]) && (m_hist[1] == m_hist[2])
              && (m_hist[2] == m_hist[3]) && (m_hist[0] != m_last);
`else
        acc = (user_input != m_last);
`endif
        if (clear) begin
            m_q.delete();
            m_ovf = 1'b0;
            m_rv  = 1'b0;
        end else begin
            popped = rd_req && (m_q.size() > 0);
            m_rv   = popped;
            if (popped) m_out = m_q.pop_front();
            if (acc && record_en) begin
                if (m_q.size() < DEPTH) m_q.push_back({counter10h, user_input});
                else m_ovf = 1'b1;
            end
        end
        if (acc) m_last = user_input;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ":count"},    32'(count),                  32'(m_q.size()));
        chk({tag, ":rd_valid"}, 32'(rd_valid),               32'(m_rv));
        chk({tag, ":pwt"},      32'(pattern_with_timestamp), 32'(m_out));
        chk({tag, ":empty"},    32'(empty),                  32'(m_q.size() == 0));
        chk({tag, ":full"},     32'(full),                   32'(m_q.size() == DEPTH));
        chk({tag, ":overflow"}, 32'(overflow),               32'(m_ovf));
    endtask

    task automatic step(input string tag);
        @(posedge clock);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        reset_n    = 1'b0;
        counter10h = 10'd5;
        user_input = 8'h00;
        record_en  = 1'b1;
        clear      = 1'b0;
        rd_req     = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clock);
        reset_n = 1'b1;

`ifdef PATTERN_RECORDER_DEBOUNCE_EN
        // Short glitch is filtered, a 4-edge hold is recorded at the 4th edge
        user_input = 8'h02;
        repeat (3) step("glitch");
        user_input = 8'h00;
        step("glitch_end");
        chk("r37_glitch_count", 32'(count), 32'd0);
        user_input = 8'h02;
        for (int t = 100; t < 104; t++) begin
            counter10h = 10'(t);
            step("hold");
        end
        chk("r37_hold_count", 32'(count), 32'd1);
        rd_req = 1'b1;
        step("r37_pop");
        rd_req = 1'b0;
        chk("r37_pwt", 32'(pattern_with_timestamp), 32'h06702);
`else
        user_input = 8'h01;
        step("r32_write");
        chk("r32_count", 32'(count), 32'd1);
        rd_req = 1'b1;
        step("r32_pop");
        rd_req = 1'b0;
        chk("r32_pwt", 32'(pattern_with_timestamp), 32'h00501);
        chk("r32_rv", 32'(rd_valid), 32'd1);
        step("r32_rv_drop");
        chk("r32_rv_one_cycle", 32'(rd_valid), 32'd0);

        repeat (20) step("r33_hold");
        record_en  = 1'b0;
        user_input = 8'h03;
        step("r33_disabled");
        record_en = 1'b1;
        step("r33_reenable");
        chk("r33_count", 32'(count), 32'd0);

        for (int i = 0; i < 17; i++) begin
            counter10h = 10'(200 + i);
            user_input = (i % 2 == 0) ? 8'hAA : 8'h55;
            step("r34_fill");
        end
        chk("r34_full", 32'(full), 32'd1);
        chk("r34_count", 32'(count), 32'd16);
        chk("r34_ovf", 32'(overflow), 32'd1);
        rd_req = 1'b1;
        for (int i = 0; i < 17; i++) step("r34_drain");
        rd_req = 1'b0;
        chk("r34_last_pop", 32'(pattern_with_timestamp), 32'({10'd215, 8'h55}));

        clear = 1'b1;
        step("r35_clear0");
        clear = 1'b0;
        for (int i = 0; i < 16; i++) begin
            counter10h = 10'(300 + i);
            user_input = 8'(i + 16);
            step("r35_fill");
        end
        user_input = 8'hF0;
        rd_req     = 1'b1;
        step("r35_wr_rd_full");
        chk("r35_rv", 32'(rd_valid), 32'd1);
        chk("r35_pwt", 32'(pattern_with_timestamp), 32'({10'd300, 8'h10}));
        chk("r35_count", 32'(count), 32'd16);
        chk("r35_ovf", 32'(overflow), 32'd0);
        clear = 1'b1;
        step("r35_clear_rd");
        clear  = 1'b0;
        rd_req = 1'b0;
        chk("r35_clr_count", 32'(count), 32'd0);
        chk("r35_clr_rv", 32'(rd_valid), 32'd0);

        counter10h = 10'd1023;
        user_input = 8'h80;
        step("r36_a");
        counter10h = 10'd0;
        user_input = 8'h40;
        step("r36_b");
        rd_req = 1'b1;
        step("r36_pop0");
        chk("r36_pwt0", 32'(pattern_with_timestamp), 32'h3FF80);
        step("r36_pop1");
        chk("r36_pwt1", 32'(pattern_with_timestamp), 32'h00040);
        user_input = 8'h41;
        step("r23_wr_rd_empty");
        rd_req = 1'b0;
        chk("r23_rv", 32'(rd_valid), 32'd0);
        chk("r23_count", 32'(count), 32'd1);
`endif

        // Asynchronous reset mid-operation discards stored entries
        user_input = 8'h07;
        repeat (6) step("pre_reset");
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_all("async_reset");
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < 400; i++) begin
            counter10h = 10'($urandom);
            if ($urandom_range(0, 5) == 0) user_input = 8'($urandom_range(0, 3));
            record_en = ($urandom_range(0, 9) != 0);
            clear     = ($urandom_range(0, 39) == 0);
            rd_req    = ($urandom_range(0, 9) < 3);
            step("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
